// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
package piso_pkg;

    typedef enum logic {
        PISO_IDLE  = 1'b0,
        PISO_SHIFT = 1'b1
    } piso_state_e;

    // Bit counter width; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Modulo-WIDTH bit position counter; at_last flags the final bit of a word.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = cnt_width(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          at_last
);

    assign at_last = (count == CW'(WIDTH - 1));

    // A clear wins over an increment so a reloaded word always restarts at bit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= at_last ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with valid/ready load, bit-order select
// and an external shift tick; back-to-back words stream without a gap.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter bit   MSB_FIRST  = 1'b0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             shift_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);

    piso_state_e      state, next_state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    bit_count;
    logic             at_last;
    logic             load;
    logic             shift;
    logic             go_idle;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PISO_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The final tick of a word doubles as a load slot, which is what lets
    // consecutive words run with no idle bit between them.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
        go_idle    = 1'b0;
        unique case (state)
            PISO_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load       = 1'b1;
                    next_state = PISO_SHIFT;
                end
            end
            PISO_SHIFT: begin
                if (shift_en) begin
                    if (at_last) begin
                        in_ready = 1'b1;
                        if (in_valid) begin
                            load = 1'b1;
                        end else begin
                            go_idle    = 1'b1;
                            next_state = PISO_IDLE;
                        end
                    end else begin
                        shift = 1'b1;
                    end
                end
            end
            default: next_state = PISO_IDLE;
        endcase
        if (rst) begin
            in_ready = 1'b0;
            load     = 1'b0;
        end
    end

    piso_bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_counter (
        .clk     (clk),
        .rst     (rst),
        .clr     (load),
        .inc     ((state == PISO_SHIFT) && shift_en),
        .count   (bit_count),
        .at_last (at_last)
    );

    assign shifted = MSB_FIRST ? (sreg << 1) : (sreg >> 1);

    // ser_out is its own flop so the link sees a clean registered bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg    <= '0;
            ser_out <= IDLE_LEVEL;
        end else if (load) begin
            sreg    <= in_data;
            ser_out <= MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
        end else if (shift) begin
            sreg    <= shifted;
            ser_out <= MSB_FIRST ? shifted[WIDTH-1] : shifted[0];
        end else if (go_idle) begin
            ser_out <= IDLE_LEVEL;
        end
    end

    assign ser_valid = (state == PISO_SHIFT);
    assign busy      = ser_valid;
    assign ser_last  = (state == PISO_SHIFT) && (bit_count == CW'(WIDTH - 1));

endmodule
